nibble_serial_addsub_ctrl: RTL

Sequencing controller that performs wide (NIBBLES×4-bit) add/subtract by time-multiplexing one 4-bit add/sub slice, one nibble per clock, LSB nibble first, with carry chained through a register. It drives the slice's operand and carry-in ports, captures its 5-bit raw sum, and assembles the wide result plus sign/zero/overflow/carryOut flags. It sits between the board switch/button logic and the existing 4-bit adder slice on the 10 MHz CLOCK domain.

---
 rtl/nibble_serial_addsub_ctrl_if.sv | 38 +++
 rtl/nibble_serial_addsub_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/nibble_serial_addsub_ctrl_if.sv
// Bus between the board-side requester, the serial add/sub controller and
// the external 4-bit add/sub slice. NIBBLES must match the controller.
interface nibble_serial_addsub_ctrl_if #(
  parameter int unsigned NIBBLES = 4
);
  localparam int unsigned W = 4 * NIBBLES;

  // request side
  logic         start;
  logic         M;
  logic [W-1:0] X;
  logic [W-1:0] Y;
  // slice side
  logic [3:0]   alu_a;
  logic [3:0]   alu_b;
  logic         alu_cin;
  logic [4:0]   alu_sum;
  // status / result
  logic         busy;
  logic         done;
  logic [W-1:0] F;
  logic         sign;
  logic         zero;
  logic         overflow;
  logic         carryOut;

  // Environment view: drives the request and the slice result back in.
  modport master (
    output start, M, X, Y, alu_sum,
    input  alu_a, alu_b, alu_cin, busy, done, F, sign, zero, overflow, carryOut
  );

  // Controller view.
  modport slave (
    input  start, M, X, Y, alu_sum,
    output alu_a, alu_b, alu_cin, busy, done, F, sign, zero, overflow, carryOut
  );
endinterface

// File: rtl/nibble_serial_addsub_ctrl.sv
// Wide add/subtract sequenced through one external 4-bit slice, LSB nibble
// first, with the carry chained through a register between nibbles.
module nibble_serial_addsub_ctrl #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                       CLOCK,
  input  logic                       RESET_N,
  nibble_serial_addsub_ctrl_if.slave bus
);
  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned CW = $clog2(NIBBLES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q;
  logic [W-1:0]  xr_q, yr_q, shadow_q, f_q;
  logic          mr_q, carry_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q, done_q, sign_q, zero_q, ovf_q, cout_q;

  logic [3:0]    x_nib, y_nib;
  logic [W-1:0]  shadow_d;
  logic [3:0]    alu_a_w, alu_b_w;
  logic          alu_cin_w;
  logic          last_nib;
  logic          ovf_d;

  // Select the current operand nibbles and merge the slice result into the shadow.
  always_comb begin
    x_nib    = '0;
    y_nib    = '0;
    shadow_d = shadow_q;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (cnt_q == CW'(i)) begin
        x_nib                = xr_q[4*i +: 4];
        y_nib                = yr_q[4*i +: 4];
        shadow_d[4*i +: 4]   = bus.alu_sum[3:0];
      end
    end
  end

  // Slice operands are driven only while running; zero otherwise.
  always_comb begin
    alu_a_w   = '0;
    alu_b_w   = '0;
    alu_cin_w = 1'b0;
    if (state_q == RUN) begin
      alu_a_w   = x_nib;
      alu_b_w   = y_nib ^ {4{mr_q}};
      alu_cin_w = carry_q;
    end
  end

  assign last_nib = (cnt_q == CW'(NIBBLES - 1));
  assign ovf_d    = (~alu_a_w[3] & ~alu_b_w[3] &  bus.alu_sum[3]) |
                    ( alu_a_w[3] &  alu_b_w[3] & ~bus.alu_sum[3]);

  // Sequencer: latch request, step one nibble per clock, publish result and flags.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      xr_q     <= '0;
      yr_q     <= '0;
      mr_q     <= 1'b0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      shadow_q <= '0;
      f_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sign_q   <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      cout_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            xr_q    <= bus.X;
            yr_q    <= bus.Y;
            mr_q    <= bus.M;
            carry_q <= bus.M;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          shadow_q <= shadow_d;
          carry_q  <= bus.alu_sum[4];
          cnt_q    <= cnt_q + CW'(1);
          if (last_nib) begin
            f_q     <= shadow_d;
            sign_q  <= shadow_d[W-1];
            zero_q  <= (shadow_d == '0);
            ovf_q   <= ovf_d;
            cout_q  <= mr_q ? ~bus.alu_sum[4] : bus.alu_sum[4];
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.alu_a    = alu_a_w;
  assign bus.alu_b    = alu_b_w;
  assign bus.alu_cin  = alu_cin_w;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.F        = f_q;
  assign bus.sign     = sign_q;
  assign bus.zero     = zero_q;
  assign bus.overflow = ovf_q;
  assign bus.carryOut = cout_q;
endmodule
